// File: rtl/pixel_scan_gen.sv
// Raster coordinate generator feeding the mandelbrot pipeline.
// Emits (x,y) in row-major order with a valid/in_enable handshake.
module pixel_scan_gen #(
   parameter logic [10:0] RESX       = 11'd640,
   parameter logic [10:0] RESY       = 11'd480,
   parameter logic        CONTINUOUS = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        in_enable,
   output logic        valid,
   output logic [10:0] xout,
   output logic [10:0] yout,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] frame_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SCAN = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // A zero-sized frame has nothing to emit, so start is never honoured.
   localparam logic RES_OK = (RESX != 11'd0) && (RESY != 11'd0);
   localparam logic [10:0] XMAX = RESX - 11'd1;
   localparam logic [10:0] YMAX = RESY - 11'd1;

   logic [1:0]  state_q, state_d;
   logic [10:0] x_q, x_d;
   logic [10:0] y_q, y_d;
   logic        valid_q, valid_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [15:0] fcnt_q, fcnt_d;

   logic xfer;
   logic last_x;
   logic last_y;

   assign xfer   = valid_q & in_enable;
   assign last_x = (x_q == XMAX);
   assign last_y = (y_q == YMAX);

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      fcnt_d  = fcnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (start && RES_OK) begin
               state_d = S_SCAN;
               valid_d = 1'b1;
               busy_d  = 1'b1;
               x_d     = 11'd0;
               y_d     = 11'd0;
            end
         end
         S_SCAN: begin
            if (xfer) begin
               if (!last_x) begin
                  x_d = x_q + 11'd1;
               end else begin
                  x_d = 11'd0;
                  if (!last_y) begin
                     y_d = y_q + 11'd1;
                  end else begin
                     y_d     = 11'd0;
                     state_d = S_DONE;
                     valid_d = 1'b0;
                     done_d  = 1'b1;
                  end
               end
            end
         end
         S_DONE: begin
            // Frame is credited on the way out of DONE.
            fcnt_d = fcnt_q + 16'd1;
            x_d    = 11'd0;
            y_d    = 11'd0;
            if (CONTINUOUS || start) begin
               state_d = S_SCAN;
               valid_d = 1'b1;
               busy_d  = 1'b1;
            end else begin
               state_d = S_IDLE;
               valid_d = 1'b0;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            x_d     = 11'd0;
            y_d     = 11'd0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         x_q     <= 11'd0;
         y_q     <= 11'd0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         fcnt_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         fcnt_q  <= fcnt_d;
      end
   end

   assign valid       = valid_q;
   assign xout        = x_q;
   assign yout        = y_q;
   assign busy        = busy_q;
   assign frame_done  = done_q;
   assign frame_count = fcnt_q;

endmodule
